// File: rtl/uart_servo_cmd.sv
// uart_servo_cmd: parses checksummed A5/ch/pw_hi/pw_lo/chk frames into per-channel
// servo pulse widths, answers each frame with ACK/NAK and drives glitch-free PWM.
module uart_servo_cmd #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned PERIOD_CYCLES  = 540_000,
    parameter int unsigned PW_MIN         = 27_000,
    parameter int unsigned PW_MAX         = 54_000,
    parameter int unsigned PW_RESET       = 40_500,
    parameter int unsigned TIMEOUT_CYCLES = 270_000
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_rx_valid,
    input  logic [7:0]          i_rx_data,
    output logic                o_tx_valid,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_ready,
    output logic [CHANNELS-1:0] o_pwm,
    output logic                o_frame_ok,
    output logic                o_frame_err
);

    localparam int unsigned PW_W  = 16;
    localparam int unsigned CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned CMP_W = (CNT_W > PW_W) ? CNT_W : PW_W;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SOF_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CH,
        S_PWH,
        S_PWL,
        S_CHK,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_ch;
    logic [7:0]        r_pwh;
    logic [7:0]        r_pwl;
    logic [7:0]        r_xor;
    logic [TO_W-1:0]   r_to_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [PW_W-1:0]   r_pend [CHANNELS];
    logic [PW_W-1:0]   r_act  [CHANNELS];

    logic              w_tx_valid_nxt;
    logic [7:0]        w_tx_data_nxt;
    logic              w_ok_nxt;
    logic              w_err_nxt;
    logic              w_commit;
    logic              w_to_hit;
    logic              w_good;
    logic              w_wrap;
    logic [PW_W-1:0]   w_pw_raw;
    logic [PW_W-1:0]   w_pw_clamped;

    assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_good   = (i_rx_data == r_xor) && (32'(r_ch) < CHANNELS);
    assign w_wrap   = (r_cnt == CNT_W'(PERIOD_CYCLES - 1));
    assign w_pw_raw = {r_pwh, r_pwl};

    always_comb begin
        w_pw_clamped = w_pw_raw;
        if (w_pw_raw < PW_W'(PW_MIN)) begin
            w_pw_clamped = PW_W'(PW_MIN);
        end else if (w_pw_raw > PW_W'(PW_MAX)) begin
            w_pw_clamped = PW_W'(PW_MAX);
        end
    end

    // Parser state register and registered response/pulse outputs
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state     <= S_IDLE;
            o_tx_valid  <= 1'b0;
            o_tx_data   <= 8'h00;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            o_tx_valid  <= w_tx_valid_nxt;
            o_tx_data   <= w_tx_data_nxt;
            o_frame_ok  <= w_ok_nxt;
            o_frame_err <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tx_valid_nxt = o_tx_valid;
        w_tx_data_nxt  = o_tx_data;
        w_ok_nxt       = 1'b0;
        w_err_nxt      = 1'b0;
        w_commit       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_rx_valid && (i_rx_data == SOF_BYTE)) begin
                    w_state_nxt = S_CH;
                end
            end
            S_CH: begin
                if (i_rx_valid) begin
                    w_state_nxt = S_PWH;
                end else if (w_to_hit) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_PWH: begin
                if (i_rx_valid) begin
                    w_state_nxt = S_PWL;
                end else if (w_to_hit) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_PWL: begin
                if (i_rx_valid) begin
                    w_state_nxt = S_CHK;
                end else if (w_to_hit) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_CHK: begin
                if (i_rx_valid) begin
                    w_state_nxt    = S_RESP;
                    w_tx_valid_nxt = 1'b1;
                    if (w_good) begin
                        w_tx_data_nxt = ACK_BYTE;
                        w_ok_nxt      = 1'b1;
                        w_commit      = 1'b1;
                    end else begin
                        w_tx_data_nxt = NAK_BYTE;
                        w_err_nxt     = 1'b1;
                    end
                end else if (w_to_hit) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_RESP: begin
                if (o_tx_valid && i_tx_ready) begin
                    w_state_nxt    = S_IDLE;
                    w_tx_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_tx_valid_nxt = 1'b0;
            end
        endcase
    end

    // Frame field capture and running checksum
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_ch  <= 8'h00;
            r_pwh <= 8'h00;
            r_pwl <= 8'h00;
            r_xor <= 8'h00;
        end else if (i_rx_valid) begin
            unique case (r_state)
                S_CH: begin
                    r_ch  <= i_rx_data;
                    r_xor <= i_rx_data;
                end
                S_PWH: begin
                    r_pwh <= i_rx_data;
                    r_xor <= r_xor ^ i_rx_data;
                end
                S_PWL: begin
                    r_pwl <= i_rx_data;
                    r_xor <= r_xor ^ i_rx_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Inter-byte gap counter; held at zero in IDLE so CH always starts fresh
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_to_cnt <= '0;
        end else if (i_rx_valid || (r_state == S_IDLE)) begin
            r_to_cnt <= '0;
        end else if (!w_to_hit) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Pending widths load into the active set only at the wrap, so no pulse is ever cut short
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                r_pend[i] <= PW_W'(PW_RESET);
                r_act[i]  <= PW_W'(PW_RESET);
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (w_commit && (r_ch == 8'(i))) begin
                    r_pend[i] <= w_pw_clamped;
                end
                if (w_wrap) begin
                    r_act[i] <= r_pend[i];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            o_pwm <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                o_pwm[i] <= (CMP_W'(r_cnt) < CMP_W'(r_act[i]));
            end
        end
    end

endmodule

// File: tb/tb_uart_servo_cmd.sv
// Bench for uart_servo_cmd: directed and random frames checked against a
// commit-history model of ACK/NAK responses and per-period pulse widths.
module tb_uart_servo_cmd;

    localparam int unsigned CH    = 4;
    localparam int unsigned P     = 2000;
    localparam int unsigned PWMIN = 300;
    localparam int unsigned PWMAX = 1200;
    localparam int unsigned PWRST = 750;
    localparam int unsigned TO    = 3000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          tx_ready = 1'b1;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic [CH-1:0] pwm;
    logic          frame_ok;
    logic          frame_err;

    always #5 clk = ~clk;

    uart_servo_cmd #(
        .CHANNELS(CH), .PERIOD_CYCLES(P), .PW_MIN(PWMIN), .PW_MAX(PWMAX),
        .PW_RESET(PWRST), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_resetn(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
        .o_pwm(pwm), .o_frame_ok(frame_ok), .o_frame_err(frame_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Posedges since reset release
    int cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    typedef struct {
        int at;
        int ch;
        int pw;
    } commit_t;
    commit_t commits[$];

    function automatic int clampw(int v);
        if (v < int'(PWMIN)) return int'(PWMIN);
        if (v > int'(PWMAX)) return int'(PWMAX);
        return v;
    endfunction

    // Width in force for the period whose wrap edge is w: last commit strictly before w
    function automatic int exp_width(int ch, int w);
        int v = int'(PWRST);
        foreach (commits[k]) begin
            if (commits[k].ch == ch && commits[k].at < w) v = commits[k].pw;
        end
        return v;
    endfunction

    int            rise_at [CH];
    bit            have_rise [CH];
    bit            in_pulse [CH];
    int            exp_w [CH];
    int            last_w [CH];
    logic [CH-1:0] pwm_q = '0;
    int            n_ok = 0;
    int            n_err = 0;
    int            n_xfer = 0;
    bit            seen_tx = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CH); i++) begin
                have_rise[i] = 1'b0;
                in_pulse[i]  = 1'b0;
            end
            pwm_q = '0;
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                if (pwm[i] && !pwm_q[i]) begin
                    check_eq($sformatf("rise_phase[%0d]", i), cyc % int'(P), 1);
                    if (have_rise[i]) check_eq($sformatf("period[%0d]", i), cyc - rise_at[i], int'(P));
                    have_rise[i] = 1'b1;
                    rise_at[i]   = cyc;
                    exp_w[i]     = exp_width(i, cyc - 1);
                    in_pulse[i]  = 1'b1;
                end else if (!pwm[i] && pwm_q[i] && in_pulse[i]) begin
                    last_w[i] = cyc - rise_at[i];
                    check_eq($sformatf("width[%0d]", i), last_w[i], exp_w[i]);
                    in_pulse[i] = 1'b0;
                end
            end
            pwm_q = pwm;
            if (frame_ok)  n_ok++;
            if (frame_err) n_err++;
            if (tx_valid)  seen_tx = 1'b1;
            if (tx_valid && tx_ready) n_xfer++;
        end
    end

    task automatic put_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo,
                              input logic [7:0] k, input bit align, input int gap,
                              input int ready_delay);
        bit         good;
        logic [7:0] resp;
        int         ok0, err0, x0, c_at;
        good = (k == (c ^ hi ^ lo)) && (int'(c) < int'(CH));
        resp = good ? 8'h06 : 8'h15;
        put_byte(8'hA5);
        put_byte(c);
        put_byte(hi);
        put_byte(lo);
        repeat (gap) begin @(posedge clk); #1; end
        if (align) begin
            while (((cyc + 2) % int'(P)) != 0) begin @(posedge clk); #1; end
        end
        ok0 = n_ok; err0 = n_err; x0 = n_xfer;
        tx_ready = (ready_delay == 0);
        put_byte(k);
        c_at = cyc;
        if (good) commits.push_back('{at: c_at, ch: int'(c), pw: clampw(int'({hi, lo}))});
        if (align) check_eq("wrap_align", c_at % int'(P), 0);
        @(negedge clk);
        check_eq("resp_valid", int'(tx_valid), 1);
        check_eq("resp_data", int'(tx_data), int'(resp));
        check_eq("ok_pulse", int'(frame_ok), int'(good));
        check_eq("err_pulse", int'(frame_err), int'(!good));
        if (ready_delay == 0) begin
            @(negedge clk);
            check_eq("resp_drop", int'(tx_valid), 0);
        end else begin
            repeat (ready_delay - 1) begin
                @(negedge clk);
                check_eq("hold_valid", int'(tx_valid), 1);
                check_eq("hold_data", int'(tx_data), int'(resp));
            end
            @(posedge clk); #1;
            tx_ready = 1'b1;
        end
        repeat (4) @(negedge clk);
        check_eq("xfer_count", n_xfer - x0, 1);
        check_eq("valid_after", int'(tx_valid), 0);
        check_eq("ok_count", n_ok - ok0, int'(good));
        check_eq("err_count", n_err - err0, int'(!good));
    endtask

    task automatic wait_cycles_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_all_widths(input string tag);
        for (int i = 0; i < int'(CH); i++)
            check_eq($sformatf("%s[%0d]", tag, i), last_w[i], exp_width(i, cyc - int'(P)));
    endtask

    initial begin
        #(10 * 200_000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int         b, x0, err0, ok0, old_w;
        logic [7:0] c, hi, lo, k, g;
        logic [15:0] pw;

        repeat (3) @(posedge clk);
        check_eq("rst_pwm", int'(pwm), 0);
        check_eq("rst_tx_valid", int'(tx_valid), 0);
        check_eq("rst_tx_data", int'(tx_data), 0);
        check_eq("rst_ok_err", int'({frame_ok, frame_err}), 0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        wait_cycles_to(2 * int'(P) + 5);
        check_eq("idle_no_tx", int'(seen_tx), 0);
        check_eq("idle_xfers", n_xfer, 0);
        check_all_widths("reset_width");

        send_frame(8'h01, 8'h9E, 8'h34, 8'hAB, 1'b0, 0, 0);
        send_frame(8'h02, 8'hFF, 8'hFF, 8'h02, 1'b0, 0, 0);
        send_frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 0, 0);
        send_frame(8'h01, 8'h04, 8'h00, 8'h05, 1'b0, 0, 0);
        send_frame(8'h01, 8'h9E, 8'h34, 8'h00, 1'b0, 0, 0);
        send_frame(8'h07, 8'h9E, 8'h34, 8'hAD, 1'b0, 0, 0);
        wait_cycles_to(cyc + 2 * int'(P) + 5);
        check_all_widths("directed_width");

        // Partial frame then silence: timeout, no response byte
        err0 = n_err; x0 = n_xfer;
        put_byte(8'h3C); put_byte(8'hA5); put_byte(8'h01); put_byte(8'h9E);
        b = cyc;
        wait_cycles_to(b + int'(TO) - 2);
        check_eq("timeout_early", n_err - err0, 0);
        wait_cycles_to(b + int'(TO) + 3);
        check_eq("timeout_err", n_err - err0, 1);
        check_eq("timeout_no_tx", n_xfer - x0, 0);
        send_frame(8'h01, 8'h02, 8'h58, 8'h5B, 1'b0, 0, 0);

        send_frame(8'h02, 8'h02, 8'h00, 8'h00, 1'b0, 0, 100);

        // Commit on the wrap edge: old width for one more period
        old_w = exp_width(3, cyc + 1);
        send_frame(8'h03, 8'h01, 8'hF4, 8'hF6, 1'b1, 0, 0);
        b = commits[$].at;
        wait_cycles_to(b + int'(PWMAX) + 5);
        check_eq("wrap_first_period", last_w[3], old_w);
        wait_cycles_to(b + int'(P) + int'(PWMAX) + 5);
        check_eq("wrap_second_period", last_w[3], 500);

        // Reset in the middle of a frame and a pulse
        wait_cycles_to(cyc + 100);
        put_byte(8'hA5); put_byte(8'h02);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_pwm", int'(pwm), 0);
        check_eq("midrst_tx_valid", int'(tx_valid), 0);
        check_eq("midrst_tx_data", int'(tx_data), 0);
        commits.delete();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        ok0 = n_ok; err0 = n_err; x0 = n_xfer;
        put_byte(8'h9E); put_byte(8'h34); put_byte(8'hA8);
        repeat (5) @(negedge clk);
        check_eq("midrst_no_ok", n_ok - ok0, 0);
        check_eq("midrst_no_err", n_err - err0, 0);
        check_eq("midrst_no_tx", n_xfer - x0, 0);

        for (int n = 0; n < 24; n++) begin
            c  = 8'($urandom_range(0, CH + 1));
            pw = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1500));
            hi = pw[15:8];
            lo = pw[7:0];
            k  = c ^ hi ^ lo;
            if ($urandom_range(0, 4) == 0) k = k ^ 8'(1 << $urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h3C;
                put_byte(g);
            end
            send_frame(c, hi, lo, k, $urandom_range(0, 7) == 0, int'($urandom_range(0, 300)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0);
        end
        wait_cycles_to(cyc + 2 * int'(P) + 5);
        check_all_widths("final_width");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_servo_cmd.md
# uart_servo_cmd

Framed-command servo controller: parses a checksummed byte stream from `uart_rx` into per-channel pulse widths and drives `CHANNELS` glitch-free servo PWM outputs. It returns a one-byte ACK/NAK to `uart_tx` for every completed frame. It replaces the fixed-width, single-channel servo path and the unframed 3-byte capture in the top level.

## Interface
Parameters:
- `CHANNELS`, 4: number of PWM outputs, 1..256.
- `PERIOD_CYCLES`, 540_000: PWM period in clocks (20 ms at 27 MHz).
- `PW_MIN`, 27_000: lowest accepted pulse width in clocks.
- `PW_MAX`, 54_000: highest accepted pulse width in clocks; must be < 65536.
- `PW_RESET`, 40_500: pulse width of every channel after reset.
- `TIMEOUT_CYCLES`, 270_000: maximum gap between bytes inside a frame.

Ports:
- `i_clk` in 1: clock.
- `i_resetn` in 1: reset. Asynchronous, active-low.
- `i_rx_valid` in 1: one-cycle strobe; `i_rx_data` is a received byte.
- `i_rx_data` in 8: received byte.
- `o_tx_valid` out 1: response byte available.
- `o_tx_data` out 8: response byte.
- `i_tx_ready` in 1: sink accepts the byte. Transfer occurs when `o_tx_valid & i_tx_ready`.
- `o_pwm` out `CHANNELS`: servo outputs.
- `o_frame_ok` out 1: one-cycle pulse when a frame is committed.
- `o_frame_err` out 1: one-cycle pulse on a NAK or a timeout.

## Operation
- Frame format is 5 bytes: `0xA5`, `ch`, `pw_hi`, `pw_lo`, `chk`, with `chk = ch ^ pw_hi ^ pw_lo`.
- Parser FSM states are IDLE, CH, PWH, PWL, CHK, RESP.
  - IDLE: a byte equal to `0xA5` moves to CH; any other byte is discarded.
  - CH, PWH and PWL each store their byte and advance to the next state.
  - CHK compares the received byte with the running XOR, then moves to RESP.
  - RESP holds `o_tx_valid`. On transfer it returns to IDLE. Bytes received while in RESP are dropped.
- Verdict in CHK:
  - A checksum mismatch or `ch >= CHANNELS` produces NAK `0x15` and a pulse on `o_frame_err`. No register changes.
  - Otherwise `pw = {pw_hi,pw_lo}` is clamped to [`PW_MIN`,`PW_MAX`] and written to `pend[ch]`. The block responds with ACK `0x06` and pulses `o_frame_ok`.
- Timeout: an inter-byte counter is cleared on every `i_rx_valid` and on entry to CH. In CH, PWH, PWL or CHK, reaching `TIMEOUT_CYCLES` without a byte returns the FSM to IDLE and pulses `o_frame_err`. No response byte is sent.
- PWM:
  - A shared counter `cnt` runs 0..`PERIOD_CYCLES-1` and wraps.
  - At the wrap (`cnt == PERIOD_CYCLES-1`), every `act[i] <= pend[i]`.
  - `o_pwm[i]` is registered from `cnt < act[i]`.
- Width rule: `pend` and `act` are 16 bits. The `cnt` width is `$clog2(PERIOD_CYCLES)`. The comparison is unsigned.

## Timing
- Reset values:
  - FSM in IDLE.
  - `cnt = 0`.
  - `pend[i] = act[i] = PW_RESET`.
  - `o_pwm = 0`, `o_tx_valid = 0`, `o_tx_data = 0x00`, `o_frame_ok = o_frame_err = 0`.
- Response latency: `o_tx_valid` rises on the cycle after the clock that samples the `chk` byte. `o_frame_ok` or `o_frame_err` pulses in that same cycle.
- `o_tx_data` is stable while `o_tx_valid` is high. `o_tx_valid` drops the cycle after the transfer. There is no limit on backpressure.
- `o_pwm[i]` is high for exactly `act[i]` consecutive cycles per period. Its rising edge comes 1 cycle after `cnt` becomes 0. The period is exactly `PERIOD_CYCLES`.
- A write becomes active at the first wrap strictly after the commit cycle. If the commit and the wrap happen on the same edge, `act` loads the old `pend` and the new value applies one period later.
- A width never changes mid-pulse.
- If a new write to the same channel arrives before the wrap, the last write wins.
- An `i_resetn` assertion mid-frame, mid-response or mid-pulse immediately forces all reset values.

## Test plan
- Reset then run 2 periods:
  - every `o_pwm` high for 40_500 cycles per 540_000.
  - no `o_tx_valid`.
- Frame A5 01 9E 34 AB with `i_tx_ready = 1`:
  - `o_tx_data = 0x06` for 1 cycle and one `o_frame_ok` pulse.
  - `o_pwm[1]` width is 40_500 from the next period.
- Frame A5 02 FF FF 02:
  - ACK `0x06`; channel 2 width is 54_000.
- Frame A5 00 00 00 00:
  - ACK `0x06`; channel 0 width is 27_000.
- Frame A5 01 9E 34 00:
  - NAK `0x15` and one `o_frame_err` pulse.
  - Channel 1 width unchanged.
- Frame A5 07 9E 34 AD with `CHANNELS = 4`:
  - NAK `0x15`; no channel changes.
- Bytes 3C A5 01 9E, then 270_000 idle cycles:
  - one `o_frame_err` pulse and no tx byte.
  - A following valid frame for channel 1 gets ACK `0x06`.
- Valid frame with `i_tx_ready = 0` for 100 cycles:
  - `o_tx_valid` and `o_tx_data = 0x06` held all 100 cycles.
  - Exactly one transfer when `i_tx_ready` rises.
- Commit on the wrap edge:
  - new width appears at the second period, not the first.
